// File: rtl/ex_pkg.sv
// Shared EX-stage definitions for the multi-cycle multiply/divide unit.
// Provides the operation codes, the FSM state encoding and small opcode
// classification helpers used by ex_muldiv and its testbench.
package ex_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MUL   = 3'd0,
    MD_MULH  = 3'd1,
    MD_MULHU = 3'd2,
    MD_DIV   = 3'd3,
    MD_MOD   = 3'd4,
    MD_DIVU  = 3'd5,
    MD_MODU  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_MOD) || (op == MD_DIVU) || (op == MD_MODU);
  endfunction

  function automatic logic md_is_signed(input logic [MD_OP_W-1:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_MOD);
  endfunction

  function automatic logic md_is_rem(input logic [MD_OP_W-1:0] op);
    return (op == MD_MOD) || (op == MD_MODU);
  endfunction

endpackage

// File: rtl/ex_md_iter.sv
// One combinational iteration of the multiply/divide datapath.
// The {hi, lo} register pair is shared by both algorithms:
//   multiply: hi = partial product, lo = remaining multiplier bits,
//             opnd = multiplicand; shift-add, shifting right.
//   divide:   hi = partial remainder, lo = dividend bits becoming quotient,
//             opnd = divisor; restoring trial subtract, shifting left.
// Ports:
//   is_div        selects the divide step
//   hi, lo, opnd  current register pair and fixed operand
//   hi_nxt/lo_nxt register pair after one step
module ex_md_iter #(
  parameter int DATA_W = 32
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] opnd,
  output logic [DATA_W-1:0] hi_nxt,
  output logic [DATA_W-1:0] lo_nxt
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[DATA_W-1]};
    // Partial remainder stays below the divisor, so shifted < 2*divisor
    // fits in DATA_W+1 bits and diff's top bit is a clean borrow flag.
    diff    = shifted - {1'b0, opnd};
    hi_nxt  = '0;
    lo_nxt  = '0;
    if (is_div) begin
      if (!diff[DATA_W]) begin
        hi_nxt = diff[DATA_W-1:0];
        lo_nxt = {lo[DATA_W-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[DATA_W-1:0];
        lo_nxt = {lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[DATA_W:1];
      lo_nxt = {sum[0], lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit for the EX stage. Accepts one operation
// per valid/ready handshake, iterates one bit per cycle on operand
// magnitudes, applies sign fix-up on the last step and holds the result
// until the MEM side accepts it.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_i                  kill any in-flight op
//   in_valid_i/in_ready_o    operation handshake (ready only in IDLE)
//   op_i, src1_i, src2_i     opcode and operands
//   rd_i, rd_we_i            writeback tag, carried to rd_o/rd_we_o
//   out_valid_o/out_ready_i  result handshake (valid only in DONE)
//   result_o                 selected result
//   busy_dest_o              pending destination for hazard detection
//
// state   | meaning
// MD_IDLE | waiting for an operation, in_ready_o high
// MD_CALC | iterating, count holds remaining steps
// MD_DONE | result held, out_valid_o high until out_ready_i
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [MD_OP_W-1:0] op_i,
  input  logic [DATA_W-1:0]  src1_i,
  input  logic [DATA_W-1:0]  src2_i,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic               rd_we_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  result_o,
  output logic [RADDR_W-1:0] rd_o,
  output logic               rd_we_o,
  output logic [RADDR_W-1:0] busy_dest_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  md_state_e state, state_nxt;

  logic [MD_OP_W-1:0] op_q;
  logic [DATA_W-1:0]  hi_q, lo_q, opnd_q;
  logic [CNT_W-1:0]   count;
  logic               neg_res_q, neg_rem_q;

  // Operation intake
  logic [MD_OP_W-1:0] op_in;
  logic               in_div, in_signed, s1, s2, div_zero, div_ovf, fast;
  logic [DATA_W-1:0]  mag1, mag2, fast_res;
  logic               accept, last;

  // Iteration and result selection
  logic [DATA_W-1:0]   hi_nxt, lo_nxt, final_res;
  logic [2*DATA_W-1:0] prod, prod_s;

  assign in_ready_o  = (state == MD_IDLE);
  assign out_valid_o = (state == MD_DONE);
  assign busy_dest_o = (state != MD_IDLE && rd_we_o) ? rd_o : '0;

  assign accept = in_valid_i && in_ready_o && !flush_i;
  assign last   = (count == CNT_W'(1));

  always_comb begin
    // Undefined opcodes quietly behave as MD_MUL.
    op_in     = (op_i > MD_MODU) ? MD_MUL : op_i;
    in_div    = md_is_div(op_in);
    in_signed = md_is_signed(op_in);
    s1        = in_signed && src1_i[DATA_W-1];
    s2        = in_signed && src2_i[DATA_W-1];
    mag1      = s1 ? -src1_i : src1_i;
    mag2      = s2 ? -src2_i : src2_i;
    div_zero  = in_div && (src2_i == '0);
    div_ovf   = in_div && in_signed && (src1_i == MIN_VAL) && (src2_i == '1);
    fast      = div_zero || div_ovf;
    fast_res  = '0;
    if (div_zero) begin
      fast_res = md_is_rem(op_in) ? src1_i : '1;
    end else if (div_ovf) begin
      fast_res = md_is_rem(op_in) ? '0 : MIN_VAL;
    end
  end

  ex_md_iter #(.DATA_W(DATA_W)) u_iter (
    .is_div (md_is_div(op_q)),
    .hi     (hi_q),
    .lo     (lo_q),
    .opnd   (opnd_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_comb begin
    prod      = {hi_nxt, lo_nxt};
    prod_s    = neg_res_q ? -prod : prod;
    final_res = prod_s[DATA_W-1:0];
    case (op_q)
      MD_MULH, MD_MULHU: final_res = prod_s[2*DATA_W-1:DATA_W];
      MD_DIV, MD_DIVU:   final_res = neg_res_q ? -lo_nxt : lo_nxt;
      MD_MOD, MD_MODU:   final_res = neg_rem_q ? -hi_nxt : hi_nxt;
      default:           final_res = prod_s[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (accept) state_nxt = fast ? MD_DONE : MD_CALC;
      MD_CALC: if (last) state_nxt = MD_DONE;
      MD_DONE: if (out_ready_i) state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
    if (flush_i) state_nxt = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      count     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
      rd_o      <= '0;
      rd_we_o   <= 1'b0;
    end else if (accept) begin
      op_q      <= op_in;
      rd_o      <= rd_i;
      rd_we_o   <= rd_we_i;
      hi_q      <= '0;
      // Divide shifts the dividend out of lo; multiply shifts the multiplier.
      lo_q      <= in_div ? mag1 : mag2;
      opnd_q    <= in_div ? mag2 : mag1;
      neg_res_q <= s1 ^ s2;
      neg_rem_q <= s1;
      count     <= CNT_W'(DATA_W);
      if (fast) result_o <= fast_res;
    end else if (state == MD_CALC && !flush_i) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      count <= count - CNT_W'(1);
      if (last) result_o <= final_res;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  import ex_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst, flush_i, in_valid_i, in_ready_o, rd_we_i;
  logic [2:0]    op_i;
  logic [DW-1:0] src1_i, src2_i, result_o;
  logic [RW-1:0] rd_i, rd_o, busy_dest_o;
  logic          out_valid_o, out_ready_i, rd_we_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.DATA_W(DW), .RADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .src1_i(src1_i), .src2_i(src2_i),
    .rd_i(rd_i), .rd_we_i(rd_we_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .rd_o(rd_o), .rd_we_o(rd_we_o),
    .busy_dest_o(busy_dest_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = longint'(a);
    longint unsigned ub = longint'(b);
    longint p;
    longint unsigned up;
    logic [63:0] w;
    if (op > 3'd6) op = 3'd0;
    case (op)
      3'd0, 3'd1: begin p = sa * sb; w = p; return (op == 3'd0) ? w[31:0] : w[63:32]; end
      3'd2: begin up = ua * ub; w = up; return w[63:32]; end
      3'd3: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; w = p; return w[31:0];
      end
      3'd4: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; w = p; return w[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges after the accepting edge until out_valid_o is seen.
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd3 && op <= 3'd6) begin
      if (b == 0) return 0;
      if ((op == 3'd3 || op == 3'd4) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    end
    return DW;
  endfunction

  task automatic start_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic we);
    int guard = 0;
    @(negedge clk);
    op_i = op; src1_i = a; src2_i = b; rd_i = rd; rd_we_i = we; in_valid_i = 1'b1;
    while (!in_ready_o && guard < 100) begin @(negedge clk); guard++; end
    check({tag, "_ready_wait"}, 64'(guard < 100), 64'(1));
    @(posedge clk);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic finish_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic we);
    int cnt = 0;
    int lat = ref_lat(op, a, b);
    if (lat > 0) check({tag, "_busy_calc"}, 64'(busy_dest_o), 64'(we ? rd : 5'd0));
    while (!out_valid_o && cnt < 100) begin @(posedge clk); #1; cnt++; end
    check({tag, "_latency"}, 64'(cnt), 64'(lat));
    check({tag, "_result"}, 64'(result_o), 64'(ref_md(op, a, b)));
    check({tag, "_rd"}, 64'({rd_we_o, rd_o}), 64'({we, rd}));
    check({tag, "_busy_done"}, 64'(busy_dest_o), 64'(we ? rd : 5'd0));
    check({tag, "_inready_done"}, 64'(in_ready_o), 64'(0));
    @(negedge clk) out_ready_i = 1'b1;
    @(posedge clk);
    #1 out_ready_i = 1'b0;
    check({tag, "_released"}, 64'({out_valid_o, in_ready_o}), 64'(2'b01));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic we);
    start_op(tag, op, a, b, rd, we);
    finish_op(tag, op, a, b, rd, we);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'( $urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] hold_res;
    int cnt;
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    op_i = '0; src1_i = '0; src2_i = '0; rd_i = '0; rd_we_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 64'(in_ready_o), 64'(1));
    check("reset_valid", 64'(out_valid_o), 64'(0));
    check("reset_result", 64'(result_o), 64'(0));
    check("reset_rd", 64'({rd_we_o, rd_o}), 64'(0));
    check("reset_busy", 64'(busy_dest_o), 64'(0));

    run_op("mul_neg",   MD_MUL,   32'd7, 32'hFFFF_FFFD, 5'd1, 1'b1);
    check("mul_neg_const", 64'(result_o), 64'(32'hFFFF_FFEB));
    run_op("mulh_neg",  MD_MULH,  32'd7, 32'hFFFF_FFFD, 5'd2, 1'b1);
    run_op("mulhu_max", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    run_op("mul_m1m1",  MD_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1);
    run_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1);
    run_op("mod_neg",   MD_MOD,   32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
    run_op("divu",      MD_DIVU,  32'd100, 32'd7, 5'd7, 1'b1);
    check("divu_const", 64'(result_o), 64'(14));
    run_op("modu",      MD_MODU,  32'd100, 32'd7, 5'd8, 1'b1);
    run_op("div_zero",  MD_DIV,   32'h1234_5678, 32'd0, 5'd9, 1'b1);
    run_op("mod_zero",  MD_MOD,   32'h1234_5678, 32'd0, 5'd10, 1'b1);
    run_op("divu_zero", MD_DIVU,  32'hDEAD_BEEF, 32'd0, 5'd11, 1'b0);
    run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1);
    run_op("mod_ovf",   MD_MOD,   32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1);
    run_op("bad_op",    3'd7,     32'hFFFF_FFFE, 32'd3, 5'd14, 1'b1);

    // Backpressure: result held while a second op is offered and refused.
    start_op("bp", MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 1'b1);
    cnt = 0;
    while (!out_valid_o && cnt < 100) begin @(posedge clk); #1; cnt++; end
    check("bp_latency", 64'(cnt), 64'(DW));
    hold_res = ref_md(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    op_i = MD_DIVU; src1_i = 32'd50; src2_i = 32'd6; rd_i = 5'd18; rd_we_i = 1'b1; in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i),
            64'({out_valid_o, in_ready_o, rd_o, result_o}),
            64'({1'b1, 1'b0, 5'd17, hold_res}));
    end
    out_ready_i = 1'b1;
    @(posedge clk);
    #1 out_ready_i = 1'b0;
    check("bp_release", 64'({out_valid_o, in_ready_o}), 64'(2'b01));
    @(posedge clk);
    #1 in_valid_i = 1'b0;
    check("bp_next_accepted", 64'(in_ready_o), 64'(0));
    finish_op("bp_next", MD_DIVU, 32'd50, 32'd6, 5'd18, 1'b1);

    // Flush on CALC cycle 10 with a competing same-cycle offer.
    start_op("fl", MD_MUL, 32'h0000_1234, 32'h0000_5678, 5'd3, 1'b1);
    repeat (9) @(posedge clk);
    #1 check("fl_busy_before", 64'(busy_dest_o), 64'(3));
    @(negedge clk);
    flush_i = 1'b1; in_valid_i = 1'b1; op_i = MD_DIVU; src1_i = 32'd9; src2_i = 32'd0;
    @(posedge clk);
    #1 flush_i = 1'b0; in_valid_i = 1'b0;
    check("fl_after", 64'({out_valid_o, in_ready_o, busy_dest_o}), 64'({1'b0, 1'b1, 5'd0}));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid_o || !in_ready_o) cnt++;
    end
    check("fl_no_result", 64'(cnt), 64'(0));

    // Reset in the middle of an iteration.
    start_op("rs", MD_DIV, 32'h7654_3210, 32'd13, 5'd21, 1'b1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rs_outputs",
          64'({in_ready_o, out_valid_o, rd_we_o, rd_o, busy_dest_o, result_o}),
          64'({1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0}));
    run_op("rs_recover", MD_DIV, 32'h7654_3210, 32'd13, 5'd21, 1'b1);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
